// File: rtl/cu_pkg.sv
// Shared definitions for the matrix-multiplier control unit: FSM states, opcodes,
// bus select / register indices, ALU operations and the control-word layout.
package cu_pkg;

    localparam int unsigned OpW    = 8;
    localparam int unsigned NumReg = 12;

    typedef enum logic [2:0] {
        StIdle,
        StFetch1,
        StFetch2,
        StDecode,
        StExec1,
        StExec2,
        StHalt
    } state_e;

    // Opcodes
    localparam logic [OpW-1:0] OpNop   = 8'h00;
    localparam logic [OpW-1:0] OpLdac  = 8'h01;
    localparam logic [OpW-1:0] OpStac  = 8'h02;
    localparam logic [OpW-1:0] OpMvacr = 8'h03;
    localparam logic [OpW-1:0] OpMvrac = 8'h04;
    localparam logic [OpW-1:0] OpAdd   = 8'h05;
    localparam logic [OpW-1:0] OpSub   = 8'h06;
    localparam logic [OpW-1:0] OpMul   = 8'h07;
    localparam logic [OpW-1:0] OpInci  = 8'h08;
    localparam logic [OpW-1:0] OpIncj  = 8'h09;
    localparam logic [OpW-1:0] OpInck  = 8'h0A;
    localparam logic [OpW-1:0] OpJmp   = 8'h0B;
    localparam logic [OpW-1:0] OpJmpz  = 8'h0C;
    localparam logic [OpW-1:0] OpClac  = 8'h0D;
    localparam logic [OpW-1:0] OpEnd   = 8'hFF;

    // Bus source select values; also the write_en bit index of each register
    localparam logic [3:0] SelPc   = 4'd0;
    localparam logic [3:0] SelDr   = 4'd1;
    localparam logic [3:0] SelTr   = 4'd2;  // tr doubles as the instruction register
    localparam logic [3:0] SelR    = 4'd3;
    localparam logic [3:0] SelAc   = 4'd4;
    localparam logic [3:0] SelDm   = 4'd5;
    localparam logic [3:0] SelIm   = 4'd6;
    localparam logic [3:0] SelR1   = 4'd7;
    localparam logic [3:0] SelR2   = 4'd8;
    localparam logic [3:0] SelRi   = 4'd9;
    localparam logic [3:0] SelRj   = 4'd10;
    localparam logic [3:0] SelRk   = 4'd11;
    localparam logic [3:0] SelZero = 4'd12;

    // inc_en bit positions
    localparam int unsigned IncPc = 0;
    localparam int unsigned IncRi = 1;
    localparam int unsigned IncRj = 2;
    localparam int unsigned IncRk = 3;

    // ALU operations
    localparam logic [2:0] AluPass  = 3'd0;
    localparam logic [2:0] AluAdd   = 3'd1;
    localparam logic [2:0] AluSub   = 3'd2;
    localparam logic [2:0] AluMul   = 3'd3;
    localparam logic [2:0] AluClear = 3'd4;

    typedef struct packed {
        logic [3:0]        read_en;
        logic [NumReg-1:0] write_en;
        logic              dm_we;
        logic [3:0]        inc_en;
        logic [2:0]        alu_op;
    } ctrl_t;

    function automatic logic is_legal(logic [OpW-1:0] op);
        return (op <= OpClac) || (op == OpEnd);
    endfunction

    // Only the memory-operand accumulator moves need a second execute cycle
    function automatic logic needs_exec2(logic [OpW-1:0] op);
        return (op == OpLdac) || (op == OpStac);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational microcode: maps {state, latched opcode, z} onto one control word.
module cu_decode
    import cu_pkg::*;
(
    input  state_e           state,
    input  logic [OpW-1:0]   opcode,
    input  logic             z,
    output ctrl_t            cw
);

    // Decode the control word; anything not listed idles the bus and strobes
    always_comb begin
        cw         = '0;
        cw.read_en = SelZero;
        unique case (state)
            StFetch2: begin
                cw.read_en          = SelIm;
                cw.write_en[SelTr]  = 1'b1;
                cw.inc_en[IncPc]    = 1'b1;
            end
            StExec1: begin
                case (opcode)
                    OpLdac, OpStac: begin
                        cw.read_en         = SelIm;
                        cw.write_en[SelDr] = 1'b1;
                        cw.inc_en[IncPc]   = 1'b1;
                    end
                    OpMvacr: begin
                        cw.read_en        = SelAc;
                        cw.write_en[SelR] = 1'b1;
                    end
                    OpMvrac: begin
                        cw.read_en         = SelR;
                        cw.write_en[SelAc] = 1'b1;
                    end
                    OpAdd, OpSub, OpMul: begin
                        cw.read_en         = SelR;
                        cw.write_en[SelAc] = 1'b1;
                        cw.alu_op          = (opcode == OpAdd) ? AluAdd :
                                             (opcode == OpSub) ? AluSub : AluMul;
                    end
                    OpInci: cw.inc_en[IncRi] = 1'b1;
                    OpIncj: cw.inc_en[IncRj] = 1'b1;
                    OpInck: cw.inc_en[IncRk] = 1'b1;
                    OpJmp: begin
                        cw.read_en         = SelIm;
                        cw.write_en[SelPc] = 1'b1;
                    end
                    OpJmpz: begin
                        if (z) begin
                            cw.read_en         = SelIm;
                            cw.write_en[SelPc] = 1'b1;
                        end else begin
                            // Not taken: step over the address operand
                            cw.inc_en[IncPc] = 1'b1;
                        end
                    end
                    OpClac: begin
                        cw.write_en[SelAc] = 1'b1;
                        cw.alu_op          = AluClear;
                    end
                    default: ;
                endcase
            end
            StExec2: begin
                if (opcode == OpLdac) begin
                    cw.read_en         = SelDm;
                    cw.write_en[SelAc] = 1'b1;
                end else if (opcode == OpStac) begin
                    cw.read_en = SelAc;
                    cw.dm_we   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Microcoded sequencer: fetch/decode/execute FSM driving the bus select,
// register load strobes, increment strobes and ALU opcode.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned IW   = 8,
    parameter int unsigned NREG = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IW-1:0]   ir,
    input  logic            z,
    output logic [3:0]      read_en,
    output logic [NREG-1:0] write_en,
    output logic            dm_we,
    output logic [3:0]      inc_en,
    output logic [2:0]      alu_op,
    output logic            done,
    output logic            err
);

    state_e          state_q, state_d;
    logic [IW-1:0]   opcode_q;
    logic            err_q;
    ctrl_t           cw;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Opcode latch and sticky illegal-opcode flag, both captured in DECODE
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= '0;
            err_q    <= 1'b0;
        end else if (state_q == StDecode) begin
            opcode_q <= ir;
            if (!is_legal(ir)) err_q <= 1'b1;
        end
    end

    // Next-state logic; DECODE looks at ir directly since the latch fills on exit
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StFetch1;
            StFetch1: state_d = StFetch2;
            StFetch2: state_d = StDecode;
            StDecode: begin
                if (ir == OpEnd)                       state_d = StHalt;
                else if (ir == OpNop || !is_legal(ir)) state_d = StFetch1;
                else                                   state_d = StExec1;
            end
            StExec1:  state_d = needs_exec2(opcode_q) ? StExec2 : StFetch1;
            StExec2:  state_d = StFetch1;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    cu_decode u_decode (
        .state  (state_q),
        .opcode (opcode_q),
        .z      (z),
        .cw     (cw)
    );

    // Moore outputs
    always_comb begin
        read_en  = cw.read_en;
        write_en = cw.write_en;
        dm_we    = cw.dm_we;
        inc_en   = cw.inc_en;
        alu_op   = cw.alu_op;
        done     = (state_q == StHalt);
        err      = err_q;
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an ISA-level model expands each program into the
// per-cycle control words it must produce; a tiny pc/ir environment feeds ir.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  ir;
    logic        z = 1'b0;
    logic [3:0]  read_en;
    logic [11:0] write_en;
    logic        dm_we;
    logic [3:0]  inc_en;
    logic [2:0]  alu_op;
    logic        done;
    logic        err;

    control_unit #(.IW(8), .NREG(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ir       (ir),
        .z        (z),
        .read_en  (read_en),
        .write_en (write_en),
        .dm_we    (dm_we),
        .inc_en   (inc_en),
        .alu_op   (alu_op),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  re;
        logic [11:0] we;
        logic        dmwe;
        logic [3:0]  inc;
        logic [2:0]  alu;
        logic        dn;
        logic        er;
    } exp_t;

    logic [7:0] im [256];
    exp_t       exp_q[$];
    bit         m_err;
    int         checks = 0;
    int         errors = 0;

    // Environment: pc and instruction register follow the DUT's strobes
    logic [7:0] env_pc, env_ir;
    assign ir = env_ir;
    always @(posedge clk) begin
        if (rst) begin
            env_pc <= 8'h00;
            env_ir <= 8'h00;
        end else begin
            if (write_en[2]) env_ir <= im[env_pc];
            if (write_en[0] && read_en == 4'd6) env_pc <= im[env_pc];
            else if (inc_en[0])                 env_pc <= env_pc + 8'd1;
        end
    end

    task automatic push(input int re, input int widx, input bit dmwe, input int inc,
                        input int alu, input bit dn);
        exp_t e;
        e.re   = re[3:0];
        e.we   = (widx >= 0) ? (12'd1 << widx) : 12'd0;
        e.dmwe = dmwe;
        e.inc  = inc[3:0];
        e.alu  = alu[2:0];
        e.dn   = dn;
        e.er   = m_err;
        exp_q.push_back(e);
    endtask

    // Walk the program at instruction level and emit the required cycle trace
    task automatic build(input int halt_cycles);
        int  pc = 0;
        bit  fin = 0;
        logic [7:0] op;
        exp_q.delete();
        m_err = 0;
        for (int n = 0; n < 64 && !fin; n++) begin
            op = im[pc[7:0]];
            pc++;
            push(12, -1, 0, 0, 0, 0);      // fetch wait
            push(6, 2, 0, 1, 0, 0);        // IR load from IM, pc+1
            push(12, -1, 0, 0, 0, 0);      // decode
            case (op)
                8'h00: ;
                8'hFF: begin
                    for (int h = 0; h < halt_cycles; h++) push(12, -1, 0, 0, 0, 1);
                    fin = 1;
                end
                8'h01: begin push(6, 1, 0, 1, 0, 0); pc++; push(5, 4, 0, 0, 0, 0); end
                8'h02: begin push(6, 1, 0, 1, 0, 0); pc++; push(4, -1, 1, 0, 0, 0); end
                8'h03: push(4, 3, 0, 0, 0, 0);
                8'h04: push(3, 4, 0, 0, 0, 0);
                8'h05, 8'h06, 8'h07: push(3, 4, 0, 0, int'(op) - 4, 0);
                8'h08, 8'h09, 8'h0A: push(12, -1, 0, 1 << (int'(op) - 7), 0, 0);
                8'h0B: begin push(6, 0, 0, 0, 0, 0); pc = int'(im[pc[7:0]]); end
                8'h0C: begin
                    if (z) begin push(6, 0, 0, 0, 0, 0); pc = int'(im[pc[7:0]]); end
                    else   begin push(12, -1, 0, 1, 0, 0); pc++; end
                end
                8'h0D: push(12, 4, 0, 0, 4, 0);
                default: m_err = 1;
            endcase
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic pin(input string name, input int idx, input int re, input int we,
                       input int inc, input int alu);
        int ok;
        ok = (idx < exp_q.size()) && exp_q[idx].re == re[3:0] && exp_q[idx].we == we[11:0]
             && exp_q[idx].inc == inc[3:0] && exp_q[idx].alu == alu[2:0];
        chk(name, ok, 1);
    endtask

    // Compare DUT outputs against the model for trace entries lo..hi-1
    task automatic compare(input string name, input int lo, input int hi);
        exp_t e;
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            e = exp_q[i];
            checks++;
            if (read_en !== e.re || write_en !== e.we || dm_we !== e.dmwe ||
                inc_en !== e.inc || alu_op !== e.alu || done !== e.dn || err !== e.er) begin
                errors++;
                $display("FAIL %s cycle %0d: got re=%0d we=%h dm=%b inc=%h alu=%0d done=%b err=%b expected re=%0d we=%h dm=%b inc=%h alu=%0d done=%b err=%b",
                         name, i, read_en, write_en, dm_we, inc_en, alu_op, done, err,
                         e.re, e.we, e.dmwe, e.inc, e.alu, e.dn, e.er);
            end
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, " read_en"}, int'(read_en), 12);
        chk({name, " strobes"}, int'({write_en, dm_we, inc_en, alu_op}), 0);
        chk({name, " done/err"}, int'({done, err}), 0);
    endtask

    // Reset, confirm idle outputs, then raise start (held for the whole run)
    task automatic reset_and_start(input string name);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle(name);
        start = 1'b1;
    endtask

    task automatic load(input logic [7:0] prog [], input logic zval);
        for (int a = 0; a < 256; a++) im[a] = 8'h00;
        foreach (prog[a]) im[a] = prog[a];
        z = zval;
    endtask

    initial begin
        logic [7:0] p [];

        // NOP, END
        p = '{8'h00, 8'hFF};
        load(p, 1'b0);
        build(4);
        pin("model nop/end fetch2", 4, 6, 12'h004, 1, 0);
        chk("model done after 6", int'(exp_q[6].dn), 1);
        reset_and_start("reset1");
        compare("nop_end", 0, exp_q.size());

        // Mixed program, z=1: LDAC, ADD, JMPZ taken, STAC, register ops, illegal, END
        p = '{8'h01, 8'h20, 8'h05, 8'h0C, 8'h06, 8'h7E, 8'h02, 8'h30, 8'h03, 8'h04,
              8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0D, 8'h7E, 8'hFF};
        load(p, 1'b1);
        build(3);
        pin("model ldac exec1", 3, 6, 12'h002, 1, 0);
        pin("model ldac exec2", 4, 5, 12'h010, 0, 0);
        pin("model add exec1", 8, 3, 12'h010, 0, 1);
        pin("model jmpz taken", 12, 6, 12'h001, 0, 0);
        chk("model final err", int'(exp_q[exp_q.size() - 1].er), 1);
        reset_and_start("reset2");
        compare("prog_a", 0, exp_q.size());

        // JMPZ not taken, JMP over an illegal byte, END
        p = '{8'h0C, 8'h40, 8'h0B, 8'h05, 8'h7E, 8'hFF};
        load(p, 1'b0);
        build(2);
        pin("model jmpz skip", 3, 12, 12'h000, 1, 0);
        pin("model jmp", 7, 6, 12'h001, 0, 0);
        reset_and_start("reset3");
        compare("prog_b", 0, exp_q.size());

        // Illegal opcode then END
        p = '{8'h7E, 8'hFF};
        load(p, 1'b0);
        build(2);
        chk("model err after illegal", int'(exp_q[3].er), 1);
        reset_and_start("reset4");
        compare("illegal_end", 0, exp_q.size());

        // Reset in EXEC1 of MUL aborts, then restart
        p = '{8'h07, 8'hFF};
        load(p, 1'b0);
        build(2);
        pin("model mul exec1", 3, 3, 12'h010, 0, 3);
        reset_and_start("reset5");
        compare("mul_pre", 0, 4);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle("abort");
        start = 1'b1;
        compare("mul_restart", 0, exp_q.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Microcoded sequencer for the single-core matrix-multiplier datapath. It fetches opcodes from instruction memory and steps a Moore FSM. Each cycle it drives the 4-bit bus source select (`read_en`), the one-hot register write enables, the increment strobes and the ALU opcode. It sits directly upstream of `bus`: it produces every `read_en` value the bus consumes, and the bus output returns to the registers this block write-enables.

## Interface
- `IW`, 8: instruction/opcode width.
- `NREG`, 12: number of bus-visible registers; width of `write_en`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: leave IDLE and begin fetching at the current PC.
- `ir` in IW: instruction register contents, valid the cycle after IR is written.
- `z` in 1: ALU zero flag, registered by the ALU.
- `read_en` out 4: bus source select. Encoding: 0 pc, 1 dr, 2 tr, 3 r, 4 ac, 5 dm, 6 im, 7 r1, 8 r2, 9 ri, 10 rj, 11 rk; 12–15 drive zero.
- `write_en` out NREG: one-hot load strobes, same index map as `read_en`. Index 2 is the IR load; `tr` is repurposed as IR.
- `dm_we` out 1: data-memory write, address `dr`, data bus.
- `inc_en` out 4: increment strobes for {rk, rj, ri, pc} (bit 0 = pc).
- `alu_op` out 3: 0 pass, 1 add, 2 sub, 3 mul, 4 clear.
- `done` out 1: high in HALT.
- `err` out 1: sticky illegal-opcode flag.

## Operation
- States: IDLE, FETCH1, FETCH2, DECODE, EXEC1, EXEC2, HALT.
- Transitions:
  - IDLE→FETCH1 on `start`.
  - FETCH1→FETCH2: IM synchronous-read wait.
  - FETCH2→DECODE: `read_en`=6, `write_en[2]`, `inc_en[0]`.
  - DECODE→EXEC1, except: NOP→FETCH1; END→HALT; illegal→FETCH1 with `err` set.
- Opcodes:
  - 0x00 NOP.
  - 0x01 LDAC a: EXEC1 `read_en`=6 into dr, inc pc; EXEC2 `read_en`=5 into ac.
  - 0x02 STAC a: EXEC1 as LDAC; EXEC2 `read_en`=4, `dm_we`.
  - 0x03 MVACR: EXEC1 `read_en`=4 into r.
  - 0x04 MVRAC: EXEC1 `read_en`=3 into ac.
  - 0x05 ADD / 0x06 SUB / 0x07 MUL: EXEC1 `read_en`=3, `alu_op`=1/2/3, write ac.
  - 0x08 INCI / 0x09 INCJ / 0x0A INCK: EXEC1 `inc_en` bit 1/2/3.
  - 0x0B JMP a: EXEC1 `read_en`=6 into pc.
  - 0x0C JMPZ a: if `z`, as JMP; else `inc_en[0]` to skip the operand.
  - 0x0D CLAC: EXEC1 `alu_op`=4, write ac.
  - 0xFF END.
- All other opcodes are illegal.
- Every EXEC path returns to FETCH1 after its last EXEC state.
- HALT holds until `rst`; `start` is ignored in HALT.
- Outputs are Moore, decoded from state plus latched opcode. In any state not listed: `read_en`=12, `write_en`=0, `dm_we`=0, `inc_en`=0, `alu_op`=0.
- At most one `write_en` bit is high per cycle.

## Timing
- Reset (`rst` high at an edge): state=IDLE, `read_en`=12, `write_en`=0, `dm_we`=0, `inc_en`=0, `alu_op`=0, `done`=0, `err`=0, opcode latch=0.
- `rst` mid-instruction aborts at the next edge. No strobe is asserted in the cycle after reset.
- Opcode latched from `ir` in DECODE. `ir` must be stable in DECODE, one cycle after the FETCH2 write.
- Instruction cycles:
  - NOP/END: 3.
  - One-EXEC instructions: 4.
  - LDAC, STAC, JMP, JMPZ: 4 or 5 as microcoded.
- `z` is sampled in EXEC1 of JMPZ only.
- `start` held high across instructions has no effect outside IDLE.
- `err` clears only on `rst`.

## Structure
- `cu_pkg`:
  - state enum;
  - opcode constants;
  - `read_en`/`write_en` index constants, shared with `bus` and the register file;
  - `alu_op` constants.
- One sub-module, `cu_decode`: combinational mapping of {state, opcode, z} to the control-word struct. The top holds the state register, opcode latch and `err`.

## Test plan
- Reset then `start`; IM holds 0x00, 0xFF → `read_en`=6 with `write_en[2]` and `inc_en[0]` in FETCH2 twice; `done`=1 after 6 cycles; `err`=0.
- LDAC 0x20, with DM[0x20]=14 → EXEC1 `read_en`=6 into dr; EXEC2 `read_en`=5 with `write_en[4]`; 5-cycle instruction.
- ADD with r=10, ac=14 → EXEC1 `read_en`=3, `alu_op`=1, `write_en[4]`; next fetch follows immediately.
- JMPZ 0x40 with `z`=1 → pc loaded from bus. Repeat with `z`=0 → `inc_en[0]` only, no pc load.
- Opcode 0x7E → `err`=1, return to FETCH1. A following END → HALT with `err` still 1.
- `rst` asserted in EXEC1 of MUL → next cycle IDLE; all strobes 0; `start` restarts fetch.
